// File: rtl/imem_boot_loader_pkg.sv
// Shared state encoding, stream-format constants and timer sizing for the
// instruction-memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 8 * LEN_BYTES;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    function automatic int timer_width(input int unsigned timeout_cycles);
        return $clog2(64'(timeout_cycles) + 64'd1);
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Assembles stream bytes little-endian into a 32-bit instruction word and
// flags the transfer that completes it.
module byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] byte_idx_q;
    logic [31:0]           word_q;

    // The incoming byte is merged combinationally so the completed word is
    // available on the same cycle as its final transfer.
    always_comb begin
        word = word_q;
        word[{byte_idx_q, 3'b000} +: 8] = byte_data;
    end

    assign word_ready = load && (byte_idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_q <= '0;
            word_q     <= '0;
        end else if (clear) begin
            byte_idx_q <= '0;
            word_q     <= '0;
        end else if (load) begin
            byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
            word_q     <= word;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: receives a length-prefixed image, writes it into
// instruction memory and holds the core in reset until the image is complete.
//
// state  | meaning
// IDLE   | waiting for start, core held
// LEN_LO | receiving word count low byte
// LEN_HI | receiving word count high byte, then range check
// DATA   | receiving bytes of the current word
// WRITE  | one-cycle instruction memory write
// DONE   | image loaded, core released
// ERR    | oversize count or idle timeout, core held
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    localparam int                   TIMER_W    = timer_width(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   word_idx_q;
    logic [TIMER_W-1:0]   timer_q;

    logic                 xfer, timed, timeout, restart, last_word;
    logic [COUNT_W-1:0]   count_full;
    logic                 pack_clear, pack_load, word_ready;
    logic [31:0]          word;

    logic                 byte_ready_d, imem_we_d, core_hold_d, done_d, error_d;
    logic [31:0]          imem_addr_d, imem_wdata_d;

    assign xfer       = byte_valid && byte_ready;
    assign timed      = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    // Timer is a down-counter reloaded on every transfer; expiry is the idle
    // cycle that would take it past zero.
    assign timeout    = timed && !xfer && (timer_q == '0);
    assign restart    = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign count_full = {byte_data, count_q[7:0]};
    assign last_word  = (word_idx_q == count_q - COUNT_W'(1));

    assign pack_clear = restart || ((state_q == LEN_HI) && xfer);
    assign pack_load  = (state_q == DATA) && xfer;

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear),
        .load       (pack_load),
        .byte_data  (byte_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            count_q    <= '0;
            word_idx_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_ready <= byte_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            core_hold  <= core_hold_d;
            done       <= done_d;
            error      <= error_d;

            if (restart) begin
                count_q    <= '0;
                word_idx_q <= '0;
                timer_q    <= TIMER_LOAD;
            end else begin
                if ((state_q == LEN_LO) && xfer) count_q[7:0] <= byte_data;
                if ((state_q == LEN_HI) && xfer) begin
                    count_q[15:8] <= byte_data;
                    word_idx_q    <= '0;
                end
                if ((state_q == WRITE) && !last_word) word_idx_q <= word_idx_q + COUNT_W'(1);
                if (timed) begin
                    if (xfer)
                        timer_q <= TIMER_LOAD;
                    else if (timer_q != '0)
                        timer_q <= timer_q - TIMER_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (xfer)         state_d = LEN_HI;
                else if (timeout) state_d = ERR;
            end
            LEN_HI: begin
                if (xfer) begin
                    if (count_full == '0)                       state_d = DONE;
                    else if (32'(count_full) > DEPTH_WORDS)     state_d = ERR;
                    else                                        state_d = DATA;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (word_ready)   state_d = WRITE;
                else if (timeout) state_d = ERR;
            end
            WRITE: begin
                state_d = last_word ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs follow directly from the state being entered.
    always_comb begin
        byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
        imem_we_d    = (state_d == WRITE);
        core_hold_d  = (state_d != DONE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        if (word_ready) begin
            imem_addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
            imem_wdata_d = word;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a stream-level model predicts every
// memory write, and literal expectations pin the model on the reference image.
module tb_imem_boot_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 64;
    localparam int          TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, core_hold, done, error;
    logic [31:0] imem_addr, imem_wdata;

    imem_boot_loader #(
        .BASE_ADDR      (BASE),
        .DEPTH_WORDS    (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Stream-level model: count, range rule, and only complete words are written.
    task automatic plan_load(input logic [7:0] s[$]);
        int cnt, avail;
        if (s.size() < 2) return;
        cnt = int'({s[1], s[0]});
        if (cnt == 0 || cnt > DEPTH) return;
        avail = (s.size() - 2) / 4;
        if (avail > cnt) avail = cnt;
        for (int i = 0; i < avail; i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back({s[2 + 4*i + 3], s[2 + 4*i + 2], s[2 + 4*i + 1], s[2 + 4*i]});
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("hold_vs_done", 32'(core_hold), 32'(!done));
            if (imem_we) begin
                log_addr.push_back(imem_addr);
                log_data.push_back(imem_wdata);
                check("ready_in_write", 32'(byte_ready), 32'd0);
                if (exp_addr.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                             imem_addr, imem_wdata);
                end else begin
                    check("write_addr", imem_addr, exp_addr.pop_front());
                    check("write_data", imem_wdata, exp_data.pop_front());
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            total++;
            $display("FAIL byte_accept: byte 0x%02h not accepted within %0d cycles", b, n);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        for (int i = 0; i < s.size(); i++)
            send_byte(s[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (!done && !error && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done && !error) begin
            total++;
            $display("FAIL wait_end: got no done/error after %0d cycles, required one", bound);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] s_norm[$];
        logic [7:0] s_big[$];
        logic [7:0] s_part[$];
        int first;

        s_norm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        s_part = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        s_big.push_back(8'h40);
        s_big.push_back(8'h00);
        for (int i = 0; i < 4 * DEPTH; i++) s_big.push_back(8'(i * 7 + 3));

        // reset state
        repeat (2) @(negedge clk);
        check("rst_core_hold", 32'(core_hold), 32'd1);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_hold", 32'(core_hold), 32'd1);

        // normal load
        log_addr.delete(); log_data.delete();
        plan_load(s_norm);
        pulse_start();
        check("start_ready", 32'(byte_ready), 32'd1);
        send_stream(s_norm, 0);
        wait_end(10);
        check("norm_done", 32'(done), 32'd1);
        check("norm_hold", 32'(core_hold), 32'd0);
        check("norm_ready", 32'(byte_ready), 32'd0);
        check("norm_pending", 32'(exp_addr.size()), 32'd0);
        check("norm_nwrites", 32'(log_addr.size()), 32'd2);
        check("norm_addr0", log_addr[0], 32'h0000_0000);
        check("norm_data0", log_data[0], 32'h00A0_0513);
        check("norm_addr1", log_addr[1], 32'h0000_0004);
        check("norm_data1", log_data[1], 32'h0010_0593);

        // zero-length load, restarted from DONE
        log_addr.delete(); log_data.delete();
        pulse_start();
        check("zero_restart_done", 32'(done), 32'd0);
        check("zero_restart_hold", 32'(core_hold), 32'd1);
        send_byte(8'h00, 0);
        check("zero_not_yet_done", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_ready", 32'(byte_ready), 32'd0);
        check("zero_nwrites", 32'(log_addr.size()), 32'd0);

        // oversize count
        pulse_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        check("over_error", 32'(error), 32'd1);
        check("over_hold", 32'(core_hold), 32'd1);
        check("over_done", 32'(done), 32'd0);
        check("over_ready", 32'(byte_ready), 32'd0);
        check("over_nwrites", 32'(log_addr.size()), 32'd0);
        pulse_start();
        check("over_restart_error", 32'(error), 32'd0);
        check("over_restart_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("over_recover_done", 32'(done), 32'd1);

        // backpressure and gaps
        log_addr.delete(); log_data.delete();
        plan_load(s_norm);
        pulse_start();
        send_stream(s_norm, 5);
        wait_end(20);
        check("gap_done", 32'(done), 32'd1);
        check("gap_pending", 32'(exp_addr.size()), 32'd0);
        check("gap_nwrites", 32'(log_addr.size()), 32'd2);
        check("gap_data1", log_data[1], 32'h0010_0593);

        // count exactly at capacity
        log_addr.delete(); log_data.delete();
        plan_load(s_big);
        pulse_start();
        send_stream(s_big, 0);
        wait_end(20);
        check("full_done", 32'(done), 32'd1);
        check("full_pending", 32'(exp_addr.size()), 32'd0);
        check("full_nwrites", 32'(log_addr.size()), 32'(DEPTH));
        check("full_last_addr", log_addr[DEPTH-1], 32'h0000_00FC);

        // timeout after a partial word
        log_addr.delete(); log_data.delete();
        plan_load(s_part);
        pulse_start();
        send_stream(s_part, 0);
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (error && first == 0) first = k;
        end
        check("timeout_latency", 32'(first), 32'(TMO));
        check("timeout_hold", 32'(core_hold), 32'd1);
        check("timeout_nwrites", 32'(log_addr.size()), 32'd0);

        // asynchronous reset between bytes 2 and 3 of a word
        log_addr.delete(); log_data.delete();
        exp_addr.delete(); exp_data.delete();
        pulse_start();
        check("mid_restart_error", 32'(error), 32'd0);
        send_stream(s_part, 0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_hold", 32'(core_hold), 32'd1);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_after_hold", 32'(core_hold), 32'd1);
        check("mid_after_ready", 32'(byte_ready), 32'd0);
        check("mid_after_nwrites", 32'(log_addr.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream program loader that writes words into instruction memory; the core only ever reads that memory.
- Holds the core in reset while a program image arrives, then releases it.
- Sits beside the processor top. `core_hold` is ORed into the core's `reset`; the `imem_*` outputs drive the instruction memory write port.
- Stream format: 16-bit word count, little-endian, followed by count×4 data bytes, each word little-endian.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- DEPTH_WORDS, 64, instruction memory capacity in words; a count above this is rejected.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while loading.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins or restarts a load.
- byte_valid  input  1  sender has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts the byte this cycle; a transfer happens when byte_valid && byte_ready.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write.
- imem_wdata  output  32  assembled instruction word.
- core_hold  output  1  keeps the core in reset while high.
- done  output  1  load completed successfully.
- error  output  1  load aborted.

Behaviour:
- Reset, asynchronous, active-high: state IDLE, core_hold=1; byte_ready, imem_we, done, error = 0; imem_addr, imem_wdata, count, word_idx, byte_idx, timer = 0.
- All outputs are registered.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE
  - core_hold=1.
  - start → LEN_LO with byte_ready=1.
- LEN_LO
  - A transfer sets count[7:0] and moves to LEN_HI.
- LEN_HI
  - A transfer sets count[15:8], then branches on the full count:
    - count==0 → DONE.
    - count>DEPTH_WORDS → ERR.
    - otherwise → DATA, word_idx=0, byte_idx=0.
- DATA
  - A transfer writes byte_data into wdata[8*byte_idx+7 : 8*byte_idx], then byte_idx++.
  - On the 4th byte, byte_ready drops in the same cycle the transition to WRITE is registered. No byte is accepted in WRITE.
- WRITE (exactly one cycle)
  - imem_we=1, imem_addr = BASE_ADDR + (word_idx<<2), imem_wdata = the assembled word.
  - If word_idx == count-1 → DONE; otherwise word_idx++, byte_idx=0, back to DATA with byte_ready=1.
  - Peak throughput: 4 bytes per 5 cycles.
- DONE
  - done=1, core_hold=0, byte_ready=0. Holds indefinitely.
- ERR
  - error=1, core_hold=1, byte_ready=0. Holds indefinitely.
- Restart from IDLE, DONE or ERR: start clears done and error, sets core_hold=1 and goes to LEN_LO. start is ignored in every other state.
- Timeout
  - In LEN_LO, LEN_HI and DATA, timer counts cycles without a transfer and clears on every transfer.
  - Reaching TIMEOUT_CYCLES → ERR. A partially assembled word is discarded, never written.
  - The timer is frozen in WRITE.
- Sender rule: byte_valid with byte_ready low is not a transfer; the sender holds its byte.
- Mid-load reset: everything returns to reset values and core_hold stays 1. Memory contents already written are left as-is.
- Address arithmetic: 32-bit, wraps modulo 2^32, no saturation.

Decomposition:
- Shared package: state enum, the LEN_BYTES=2 and BYTES_PER_WORD=4 constants, and the timer width function clog2(TIMEOUT_CYCLES+1).
- One natural sub-module, `byte_word_packer`: byte_idx counter plus little-endian assembly register, with a `word_ready` output.
- The FSM, timer and address logic stay in the top.

Test Plan:
- Normal load
  - Stimulus: reset released, start, stream 02 00 13 05 A0 00 93 05 10 00.
  - Required response: imem_we pulses twice, at addr 0x0 with 0x00A00513 and at addr 0x4 with 0x00100593; then done=1, core_hold=0, byte_ready=0.
- Zero-length load
  - Stimulus: start, stream 00 00.
  - Required response: no imem_we; done=1 on the cycle after the second byte.
- Oversize count
  - Stimulus: start, stream 41 00 (65 > 64).
  - Required response: error=1, core_hold=1, no writes. A following start returns to LEN_LO with error=0.
- Backpressure and gaps
  - Stimulus: byte_valid toggled randomly with gaps under TIMEOUT_CYCLES (set to 16).
  - Required response: same words and addresses as the normal load; byte_ready=0 in every WRITE cycle.
- Timeout
  - Stimulus: TIMEOUT_CYCLES=16, start, 01 00 AA BB, then silence.
  - Required response: error=1 exactly 16 cycles after the BB transfer; no imem_we.
- Reset mid-load
  - Stimulus: assert reset asynchronously between bytes 2 and 3 of a word.
  - Required response: all outputs at reset values immediately; core_hold=1; no write issued.
